// File: rtl/gsim_result_collector.sv
// gsim_result_collector
//
// Purpose: sits after the Gauss-Seidel solver. Captures one solution frame
// of N_WORDS signed 16.16 words into a local buffer, works out the largest
// absolute change against the previous complete frame, then replays the
// frame to a consumer over a valid/ready stream.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; aborts any capture or drain
//   x_valid      solver out_valid, high for N_WORDS cycles per frame
//   x_in         solver word, sampled while x_valid is high
//   m_valid      stream word available (only in DRAIN)
//   m_ready      consumer ready
//   m_data       buffered word at the read pointer
//   m_index      index of m_data
//   m_last       high with the final index
//   delta_max    max |x_new - x_prev| over the last complete frame
//   delta_valid  one-cycle pulse when delta_max updates
//   overflow     sticky: x_valid seen while draining
//   frame_err    sticky: x_valid dropped mid-frame
//   busy         high in CAPTURE or DRAIN
//   dbg_state    FSM state (0=IDLE, 1=CAPTURE, 2=DRAIN)
//
// Stream handshake: a word transfers on a rising edge where m_valid and
// m_ready are both high. While m_valid is high and m_ready is low,
// m_data/m_index/m_last hold, and m_valid never drops until the transfer.

module gsim_result_collector #(
    parameter int N_WORDS = 16,
    parameter int DW      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       x_valid,
    input  logic [DW-1:0]              x_in,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DW-1:0]              m_data,
    output logic [$clog2(N_WORDS)-1:0] m_index,
    output logic                       m_last,
    output logic [DW-1:0]              delta_max,
    output logic                       delta_valid,
    output logic                       overflow,
    output logic                       frame_err,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    localparam int IW = $clog2(N_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   rd_q, rd_d;
    logic            xv_prev_q;
    logic            prev_ok_q, prev_ok_d;
    logic [DW-1:0]   run_max_q, run_max_d;
    logic [DW-1:0]   delta_max_q, delta_max_d;
    logic            delta_valid_q, delta_valid_d;
    logic            overflow_q, overflow_d;
    logic            frame_err_q, frame_err_d;

    logic [DW-1:0]   mem_q  [N_WORDS];
    logic [DW-1:0]   prev_q [N_WORDS];

    // Capture write: a frame starts only on a rising x_valid in IDLE, so the
    // tail of a dropped or overflowed burst never looks like a new frame.
    logic            start_cap;
    logic            cap_we;
    logic [IW-1:0]   wr_idx;
    logic [DW-1:0]   prev_word;
    logic [DW:0]     diff;
    logic [DW:0]     diff_abs;
    logic [DW-1:0]   abs_sat;
    logic [DW-1:0]   max_next;

    assign start_cap = (state_q == ST_IDLE) && x_valid && !xv_prev_q;
    assign cap_we    = !reset && (start_cap || ((state_q == ST_CAPTURE) && x_valid));
    assign wr_idx    = (state_q == ST_IDLE) ? '0 : cnt_q;
    assign prev_word = prev_q[wr_idx];

    // 33-bit two's-complement difference so the full signed range never wraps.
    assign diff     = {x_in[DW-1], x_in} - {prev_word[DW-1], prev_word};
    assign diff_abs = diff[DW] ? (~diff + 1'b1) : diff;
    assign abs_sat  = diff_abs[DW] ? '1 : diff_abs[DW-1:0];
    // The first word of a frame restarts the running max.
    assign max_next = (state_q == ST_IDLE || abs_sat > run_max_q) ? abs_sat : run_max_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_d          = rd_q;
        prev_ok_d     = prev_ok_q;
        run_max_d     = run_max_q;
        delta_max_d   = delta_max_q;
        delta_valid_d = 1'b0;
        overflow_d    = overflow_q;
        frame_err_d   = frame_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_cap) begin
                    cnt_d     = IW'(1);
                    run_max_d = max_next;
                    state_d   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (x_valid) begin
                    cnt_d     = cnt_q + 1'b1;
                    run_max_d = max_next;
                    if (cnt_q == LAST_IDX) begin
                        // Frame complete: publish metric as the drain begins.
                        state_d       = ST_DRAIN;
                        cnt_d         = '0;
                        rd_d          = '0;
                        delta_valid_d = 1'b1;
                        delta_max_d   = prev_ok_q ? max_next : '1;
                        prev_ok_d     = 1'b1;
                    end
                end else begin
                    // prev[] is now partially overwritten, so it is no longer
                    // a valid reference frame.
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                    prev_ok_d   = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (x_valid) begin
                    overflow_d = 1'b1;
                end
                if (m_ready) begin
                    if (rd_q == LAST_IDX) begin
                        rd_d    = '0;
                        state_d = ST_IDLE;
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rd_q          <= '0;
            xv_prev_q     <= 1'b0;
            prev_ok_q     <= 1'b0;
            run_max_q     <= '0;
            delta_max_q   <= '0;
            delta_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_q          <= rd_d;
            xv_prev_q     <= x_valid;
            prev_ok_q     <= prev_ok_d;
            run_max_q     <= run_max_d;
            delta_max_q   <= delta_max_d;
            delta_valid_q <= delta_valid_d;
            overflow_q    <= overflow_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Frame buffer and reference frame carry no reset.
    always_ff @(posedge clk) begin
        if (cap_we) begin
            mem_q[wr_idx]  <= x_in;
            prev_q[wr_idx] <= x_in;
        end
    end

    assign m_valid     = (state_q == ST_DRAIN);
    assign m_data      = m_valid ? mem_q[rd_q] : '0;
    assign m_index     = m_valid ? rd_q : '0;
    assign m_last      = m_valid && (rd_q == LAST_IDX);
    assign delta_max   = delta_max_q;
    assign delta_valid = delta_valid_q;
    assign overflow    = overflow_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_gsim_result_collector.sv
// Bench for gsim_result_collector: directed frames with hand-computed delta
// values; the stream and delta outputs are checked by a monitor against
// expected queues filled when each frame is issued.

module tb_gsim_result_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        x_valid;
    logic [31:0] x_in;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_index;
    logic        m_last;
    logic [31:0] delta_max;
    logic        delta_valid;
    logic        overflow;
    logic        frame_err;
    logic        busy;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    // Stream expectation: {last, index, data}
    logic [36:0] exp_q[$];
    logic [31:0] dexp_q[$];
    logic [31:0] frame [16];

    gsim_result_collector dut (
        .clk         (clk),
        .reset       (reset),
        .x_valid     (x_valid),
        .x_in        (x_in),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_index     (m_index),
        .m_last      (m_last),
        .delta_max   (delta_max),
        .delta_valid (delta_valid),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] exp_delta);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({(i == 15), 4'(i), frame[i]});
        end
        dexp_q.push_back(exp_delta);
    endtask

    task automatic send_words(input int n);
        for (int i = 0; i < n; i++) begin
            x_valid = 1'b1;
            x_in    = frame[i];
            @(posedge clk); #1;
        end
        x_valid = 1'b0;
        x_in    = '0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (busy && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check({name, "_busy_timeout"}, 32'(busy), 32'd0);
        check({name, "_all_words_seen"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_unexpected: got idx %0d data %h, none expected", m_index, m_data);
                end else begin
                    if ({m_last, m_index, m_data} !== exp_q[0]) begin
                        errors++;
                        $display("FAIL stream_word: got last %b idx %0d data %h expected last %b idx %0d data %h",
                                 m_last, m_index, m_data, exp_q[0][36], exp_q[0][35:32], exp_q[0][31:0]);
                    end
                    if (m_ready) void'(exp_q.pop_front());
                end
            end
            if (delta_valid) begin
                checks++;
                if (dexp_q.size() == 0) begin
                    errors++;
                    $display("FAIL delta_unexpected: got delta_max %h, no pulse expected", delta_max);
                end else begin
                    if (delta_max !== dexp_q[0]) begin
                        errors++;
                        $display("FAIL delta_max: got %h expected %h", delta_max, dexp_q[0]);
                    end
                    void'(dexp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] pat;
        int k;
        pat     = 4'b1001;
        reset   = 1'b1;
        x_valid = 1'b0;
        x_in    = '0;
        m_ready = 1'b1;
        idle_cycles(3);
        reset = 1'b0;

        check("reset_m_valid",   32'(m_valid), 32'd0);
        check("reset_delta_max", delta_max, 32'd0);
        check("reset_flags",     {28'd0, overflow, frame_err, busy, delta_valid}, 32'd0);

        // 1: ramp frame, first frame reports all-ones
        for (int i = 0; i < 16; i++) frame[i] = i << 16;
        push_frame(32'hFFFF_FFFF);
        send_words(16);
        check("t1_m_valid_latency", 32'(m_valid), 32'd1);
        check("t1_delta_valid", 32'(delta_valid), 32'd1);
        wait_idle("t1");

        // 2: +0x8000 everywhere, x[7] is 0x8000 below its previous value
        for (int i = 0; i < 16; i++) frame[i] = (i << 16) + 32'h8000;
        frame[7] = 32'h0006_8000;
        push_frame(32'h0000_8000);
        send_words(16);
        idle_cycles(1);
        check("t2_delta_pulse_width", 32'(delta_valid), 32'd0);
        check("t2_delta_hold", delta_max, 32'h0000_8000);
        wait_idle("t2");

        // 3: max positive then max negative -> saturated, no wrap
        for (int i = 0; i < 16; i++) frame[i] = 32'h7FFF_FFFF;
        push_frame(32'h7FFF_7FFF);
        send_words(16);
        wait_idle("t3a");
        for (int i = 0; i < 16; i++) frame[i] = 32'h8000_0000;
        push_frame(32'hFFFF_FFFF);
        send_words(16);
        wait_idle("t3b");

        // 4: m_ready 1,0,0,1 during drain
        for (int i = 0; i < 16; i++) frame[i] = 32'h8000_0000 + 32'(i * 3);
        push_frame(32'h0000_002D);
        send_words(16);
        k = 0;
        while (busy && k < 200) begin
            m_ready = pat[3 - (k % 4)];
            @(posedge clk); #1;
            k++;
        end
        m_ready = 1'b1;
        check("t4_busy_after_last", 32'(busy), 32'd0);
        check("t4_all_words_seen", 32'(exp_q.size()), 32'd0);
        check("t4_overflow_clear", 32'(overflow), 32'd0);

        // 5: second burst while draining is dropped
        for (int i = 0; i < 16; i++) frame[i] = 32'h8000_0010;
        m_ready = 1'b0;
        push_frame(32'h0000_001D);
        send_words(16);
        idle_cycles(1);
        for (int i = 0; i < 16; i++) frame[i] = 32'h1234_5678;
        send_words(16);
        check("t5_overflow", 32'(overflow), 32'd1);
        check("t5_still_draining", 32'(busy), 32'd1);
        m_ready = 1'b1;
        wait_idle("t5a");
        idle_cycles(1);
        // Reference must still be the drained frame, not the dropped burst.
        for (int i = 0; i < 16; i++) frame[i] = 32'h8000_0000;
        push_frame(32'h0000_0010);
        send_words(16);
        wait_idle("t5b");
        check("t5_overflow_sticky", 32'(overflow), 32'd1);

        // 6: short frame -> frame_err, no stream, next frame reports all-ones
        for (int i = 0; i < 16; i++) frame[i] = 32'h0000_1111;
        send_words(9);
        idle_cycles(2);
        check("t6_frame_err", 32'(frame_err), 32'd1);
        check("t6_idle_after_err", 32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) frame[i] = 32'h0000_0005;
        push_frame(32'hFFFF_FFFF);
        send_words(16);
        wait_idle("t6a");

        // 6b: reset mid-drain
        for (int i = 0; i < 16; i++) frame[i] = 32'h0000_0007;
        m_ready = 1'b0;
        push_frame(32'h0000_0002);
        send_words(16);
        idle_cycles(3);
        check("t6_stalled_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        check("t6_reset_m_valid", 32'(m_valid), 32'd0);
        check("t6_reset_flags", {28'd0, overflow, frame_err, busy, delta_valid}, 32'd0);
        check("t6_reset_delta_max", delta_max, 32'd0);
        reset   = 1'b0;
        m_ready = 1'b1;
        idle_cycles(3);
        check("t6_no_stream_after_reset", 32'(m_valid), 32'd0);
        check("end_delta_queue_empty", 32'(dexp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
